// File: rtl/spi_pkg.sv
// Shared types and bit positions for the SPI master sequencer.
package spi_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

   localparam int CTL_TE = 2;
   localparam int CTL_LB = 3;
   localparam int CTL_RE = 6;

   localparam int ST_BUSY        = 0;
   localparam int ST_TX_FULL     = 1;
   localparam int ST_RX_OVERRUN  = 2;
   localparam int ST_TX_OVERLOAD = 3;
   localparam int ST_RX_FULL     = 4;

   // Width of a counter that runs 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: CLK_DIV cycles per half-period, registered SCLK level and
// strobes flagging the clock edge at which SCLK will rise or fall.
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic sclk,
   output logic sclk_rise,
   output logic sclk_fall
);

   localparam int            CW   = cnt_w(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          wrap;

   always_comb begin
      wrap   = en && !restart && (cnt_q == LAST);
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (restart) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (en) begin
         if (wrap) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk      = sclk_q;
   assign sclk_rise = wrap && !sclk_q;
   assign sclk_fall = wrap && sclk_q;

endmodule

// File: rtl/spi_master_sequencer.sv
// SPI mode-0 master, one MSB-first frame at a time between TX/RX holding buffers.
// Optional SPI_LOOPBACK_EN: CONTROL[3] samples MOSI instead of MISO.
module spi_master_sequencer
   import spi_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic [7:0]        CONTROL,
   input  logic              WRITE,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              READ,
   input  logic              CLEAR_FLAGS,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic [7:0]        STATUS,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
   output logic              CS_N
);

   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int PH_W   = cnt_w(PH_MAX);

   state_e            state_q, state_d;
   logic              cs_n_q, cs_n_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] cap_q, cap_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
   logic              tx_full_q, tx_full_d;
   logic [DATA_W-1:0] rx_buf_q, rx_buf_d;
   logic              rx_full_q, rx_full_d;
   logic              ovr_q, ovr_d;
   logic              ovl_q, ovl_d;

   logic sclk, sclk_rise, sclk_fall;
   logic unload, capture, tx_accept, rx_take, ovr_set, sample_bit;
   logic unused_ctl;

   assign unused_ctl = ^CONTROL;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk       (CLK),
      .rst       (CLR),
      .en        (state_q == SHIFT),
      .restart   (state_q != SHIFT),
      .sclk      (sclk),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall)
   );

`ifdef SPI_LOOPBACK_EN
   assign sample_bit = CONTROL[CTL_LB] ? shreg_q[DATA_W-1] : MISO;
`else
   assign sample_bit = MISO;
`endif

   always_comb begin
      state_d   = state_q;
      cs_n_d    = cs_n_q;
      shreg_d   = shreg_q;
      cap_d     = cap_q;
      bit_d     = bit_q;
      ph_d      = ph_q;
      tx_buf_d  = tx_buf_q;
      tx_full_d = tx_full_q;
      rx_buf_d  = rx_buf_q;
      rx_full_d = rx_full_q;
      unload    = 1'b0;
      capture   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (tx_full_q && CONTROL[CTL_TE]) begin
               unload  = 1'b1;
               shreg_d = tx_buf_q;
               cs_n_d  = 1'b0;
               ph_d    = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (ph_q == PH_W'(CS_SETUP - 1)) begin
               bit_d   = '0;
               state_d = SHIFT;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         SHIFT: begin
            if (sclk_rise) cap_d = {cap_q[DATA_W-2:0], sample_bit};
            // The final fall ends the frame without shifting, so MOSI holds the LSB through HOLD.
            if (sclk_fall) begin
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  capture = 1'b1;
                  ph_d    = '0;
                  state_d = HOLD;
               end else begin
                  shreg_d = shreg_q << 1;
                  bit_d   = bit_q + BIT_W'(1);
               end
            end
         end
         HOLD: begin
            if (ph_q == PH_W'(CS_HOLD - 1)) begin
               cs_n_d  = 1'b1;
               state_d = IDLE;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      tx_accept = WRITE && (!tx_full_q || unload);
      if (tx_accept) begin
         tx_buf_d  = DATA_IN;
         tx_full_d = 1'b1;
      end else if (unload) begin
         tx_full_d = 1'b0;
      end
      ovl_d = (ovl_q && !CLEAR_FLAGS) || (WRITE && !tx_accept);

      // A READ in the capture cycle frees the buffer just in time for the new word.
      rx_take = capture && CONTROL[CTL_RE] && (!rx_full_q || READ);
      ovr_set = capture && CONTROL[CTL_RE] && rx_full_q && !READ;
      if (rx_take) begin
         rx_buf_d  = cap_q;
         rx_full_d = 1'b1;
      end else if (READ) begin
         rx_full_d = 1'b0;
      end
      ovr_d = (ovr_q && !CLEAR_FLAGS) || ovr_set;
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q   <= IDLE;
         cs_n_q    <= 1'b1;
         shreg_q   <= '0;
         cap_q     <= '0;
         bit_q     <= '0;
         ph_q      <= '0;
         tx_buf_q  <= '0;
         tx_full_q <= 1'b0;
         rx_buf_q  <= '0;
         rx_full_q <= 1'b0;
         ovr_q     <= 1'b0;
         ovl_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cs_n_q    <= cs_n_d;
         shreg_q   <= shreg_d;
         cap_q     <= cap_d;
         bit_q     <= bit_d;
         ph_q      <= ph_d;
         tx_buf_q  <= tx_buf_d;
         tx_full_q <= tx_full_d;
         rx_buf_q  <= rx_buf_d;
         rx_full_q <= rx_full_d;
         ovr_q     <= ovr_d;
         ovl_q     <= ovl_d;
      end
   end

   assign DATA_OUT = rx_buf_q;
   assign STATUS   = {3'b000, rx_full_q, ovl_q, ovr_q, tx_full_q, (state_q != IDLE)};
   assign SCLK     = sclk;
   assign MOSI     = shreg_q[DATA_W-1];
   assign CS_N     = cs_n_q;

endmodule
